// File: rtl/bp_pkg.sv
// ============================================================================
// Module  : bp_pkg
// Brief   : Shared types and helpers for the branch predictor (2-bit counters).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;

    function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
        ctr_t nxt;
        nxt = ctr;
        unique case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_if.sv
// ============================================================================
// Module  : branch_predictor_if
// Brief   : IF lookup and EX resolve signals between the pipeline and the BTB.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;

    modport master (
        output if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  if_pred_taken, if_pred_target, ex_mispredict, ex_redirect_pc
    );

    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_is_branch, ex_is_jal, ex_is_jalr,
               ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output if_pred_taken, if_pred_target, ex_mispredict, ex_redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/bp_table.sv
// ============================================================================
// Module  : bp_table
// Brief   : BTB storage: two combinational read ports, one synchronous write.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_table
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8,
    localparam int IDX     = $clog2(ENTRIES)
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [IDX-1:0]      rd_a_idx,
    output logic                     rd_a_valid,
    output logic [TAG_BITS-1:0]      rd_a_tag,
    output ctr_t                     rd_a_ctr,
    output logic [31:0]              rd_a_target,
    input  wire logic [IDX-1:0]      rd_b_idx,
    output logic                     rd_b_valid,
    output logic [TAG_BITS-1:0]      rd_b_tag,
    output ctr_t                     rd_b_ctr,
    output logic [31:0]              rd_b_target,
    input  wire logic                wr_en,
    input  wire logic [IDX-1:0]      wr_idx,
    input  wire logic                wr_valid,
    input  wire logic [TAG_BITS-1:0] wr_tag,
    input  wire ctr_t                wr_ctr,
    input  wire logic [31:0]         wr_target
);

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    ctr_t                r_ctr    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_ctr[i]    <= CTR_RESET;
                r_target[i] <= 32'd0;
            end
        end else if (wr_en) begin
            r_valid[wr_idx]  <= wr_valid;
            r_tag[wr_idx]    <= wr_tag;
            r_ctr[wr_idx]    <= wr_ctr;
            r_target[wr_idx] <= wr_target;
        end
    end

    // Reads see pre-write contents; there is deliberately no write bypass.
    assign rd_a_valid  = r_valid[rd_a_idx];
    assign rd_a_tag    = r_tag[rd_a_idx];
    assign rd_a_ctr    = r_ctr[rd_a_idx];
    assign rd_a_target = r_target[rd_a_idx];

    assign rd_b_valid  = r_valid[rd_b_idx];
    assign rd_b_tag    = r_tag[rd_b_idx];
    assign rd_b_ctr    = r_ctr[rd_b_idx];
    assign rd_b_target = r_target[rd_b_idx];

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module  : branch_predictor
// Brief   : Direct-mapped BTB with 2-bit counters; optional BP_STATS_EN stats.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    branch_predictor_if.slave  bp
`ifdef BP_STATS_EN
    ,
    output logic [31:0]        stat_resolved,
    output logic [31:0]        stat_mispredicts
`endif
);

    localparam int IDX = $clog2(ENTRIES);

    logic [IDX-1:0]      w_if_idx,  w_ex_idx;
    logic [TAG_BITS-1:0] w_if_tag,  w_ex_tag;
    logic                w_a_valid, w_b_valid;
    logic [TAG_BITS-1:0] w_a_tag,   w_b_tag;
    ctr_t                w_a_ctr,   w_b_ctr;
    logic [31:0]         w_a_target, w_b_target;
    logic                w_if_hit,  w_ex_hit;
    logic                w_actual_taken;
    logic                w_mispredict;
    logic                w_wr_en;
    logic                w_wr_valid;
    ctr_t                w_wr_ctr;
    logic [31:0]         w_wr_target;

    assign w_if_idx = bp.if_pc[IDX+1:2];
    assign w_if_tag = bp.if_pc[IDX+TAG_BITS+1:IDX+2];
    assign w_ex_idx = bp.ex_pc[IDX+1:2];
    assign w_ex_tag = bp.ex_pc[IDX+TAG_BITS+1:IDX+2];

    bp_table #(
        .ENTRIES  (ENTRIES),
        .TAG_BITS (TAG_BITS)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .rd_a_idx    (w_if_idx),
        .rd_a_valid  (w_a_valid),
        .rd_a_tag    (w_a_tag),
        .rd_a_ctr    (w_a_ctr),
        .rd_a_target (w_a_target),
        .rd_b_idx    (w_ex_idx),
        .rd_b_valid  (w_b_valid),
        .rd_b_tag    (w_b_tag),
        .rd_b_ctr    (w_b_ctr),
        .rd_b_target (w_b_target),
        .wr_en       (w_wr_en),
        .wr_idx      (w_ex_idx),
        .wr_valid    (w_wr_valid),
        .wr_tag      (w_ex_tag),
        .wr_ctr      (w_wr_ctr),
        .wr_target   (w_wr_target)
    );

    assign w_if_hit = w_a_valid & (w_a_tag == w_if_tag);
    assign w_ex_hit = w_b_valid & (w_b_tag == w_ex_tag);

    assign bp.if_pred_taken  = w_if_hit & w_a_ctr[1];
    assign bp.if_pred_target = (w_if_hit & w_a_ctr[1]) ? w_a_target : 32'd0;

    assign w_actual_taken = bp.ex_is_jal | bp.ex_is_jalr | (bp.ex_is_branch & bp.ex_taken);
    assign w_mispredict   = ~rst & bp.ex_valid &
                            ((w_actual_taken != bp.ex_pred_taken) |
                             (w_actual_taken & (bp.ex_target != bp.ex_pred_target)));

    assign bp.ex_mispredict  = w_mispredict;
    assign bp.ex_redirect_pc = (~rst & bp.ex_valid) ?
                               (w_actual_taken ? bp.ex_target : bp.ex_pc + 32'd4) : 32'd0;

    // Unwritten fields default to the current entry so partial updates keep them.
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_valid  = w_b_valid;
        w_wr_ctr    = w_b_ctr;
        w_wr_target = w_b_target;
        if (bp.ex_valid) begin
            if (bp.ex_is_jal) begin
                w_wr_en     = 1'b1;
                w_wr_valid  = 1'b1;
                w_wr_ctr    = ST;
                w_wr_target = bp.ex_target;
            end else if (bp.ex_is_jalr) begin
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b0;
            end else if (bp.ex_is_branch) begin
                if (w_ex_hit) begin
                    w_wr_en  = 1'b1;
                    w_wr_ctr = sat_update(w_b_ctr, bp.ex_taken);
                    if (bp.ex_taken) begin
                        w_wr_target = bp.ex_target;
                    end
                end else if (bp.ex_taken) begin
                    w_wr_en     = 1'b1;
                    w_wr_valid  = 1'b1;
                    w_wr_ctr    = WT;
                    w_wr_target = bp.ex_target;
                end
            end else if (w_ex_hit) begin
                w_wr_en    = 1'b1;
                w_wr_valid = 1'b0;
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved    <= 32'd0;
            stat_mispredicts <= 32'd0;
        end else begin
            if (bp.ex_valid & (bp.ex_is_branch | bp.ex_is_jal | bp.ex_is_jalr)) begin
                stat_resolved <= stat_resolved + 32'd1;
            end
            if (w_mispredict) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module  : tb_branch_predictor
// Brief   : Directed plus randomized bench for branch_predictor with a BTB model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    localparam int ENTRIES  = 64;
    localparam int TAG_BITS = 8;
    localparam int IDX      = $clog2(ENTRIES);
    localparam int K_NONE = 0, K_BR = 1, K_JAL = 2, K_JALR = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if bus ();

`ifdef BP_STATS_EN
    logic [31:0] stat_resolved, stat_mispredicts;
    branch_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS)) dut (
        .clk(clk), .rst(rst), .bp(bus),
        .stat_resolved(stat_resolved), .stat_mispredicts(stat_mispredicts));
`else
    branch_predictor #(.ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS)) dut (
        .clk(clk), .rst(rst), .bp(bus));
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one record per index, counter as an integer 0..3.
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_res, m_mis;

    bit          p_en;
    int          p_idx;
    bit          p_valid;
    int          p_tag, p_ctr;
    logic [31:0] p_tgt;
    bit          p_res, p_mis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (IDX + 2)) % (1 << TAG_BITS));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    initial begin
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
        end
        m_res = 0; m_mis = 0; p_en = 0; p_res = 0; p_mis = 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
            end
            m_res = 0; m_mis = 0;
        end else begin
            if (p_en) begin
                m_valid[p_idx] = p_valid; m_tag[p_idx] = p_tag;
                m_ctr[p_idx]   = p_ctr;   m_tgt[p_idx] = p_tgt;
            end
            m_res = m_res + (p_res ? 1 : 0);
            m_mis = m_mis + (p_mis ? 1 : 0);
        end
    end

    // Compare process: check outputs mid-cycle, then stage what the next edge does.
    always @(negedge clk) begin
        bit          e_pt, act, e_mp, hit, br, jal, jalr;
        logic [31:0] e_ptg, e_red;
        int          i;
        p_en = 0; p_res = 0; p_mis = 0;
        if (rst) begin
            chk("pred_taken_rst",  {31'd0, bus.if_pred_taken}, 32'd0);
            chk("pred_target_rst", bus.if_pred_target,         32'd0);
            chk("mispredict_rst",  {31'd0, bus.ex_mispredict}, 32'd0);
            chk("redirect_rst",    bus.ex_redirect_pc,         32'd0);
        end else begin
            i     = idx_of(bus.if_pc);
            e_pt  = m_hit(bus.if_pc) && (m_ctr[i] >= 2);
            e_ptg = e_pt ? m_tgt[i] : 32'd0;
            br    = bus.ex_is_branch; jal = bus.ex_is_jal; jalr = bus.ex_is_jalr;
            act   = jal || jalr || (br && bus.ex_taken);
            e_mp  = bus.ex_valid && ((act != bus.ex_pred_taken) ||
                                     (act && bus.ex_target != bus.ex_pred_target));
            e_red = !bus.ex_valid ? 32'd0 : (act ? bus.ex_target : bus.ex_pc + 32'd4);
            chk("pred_taken",  {31'd0, bus.if_pred_taken}, {31'd0, e_pt});
            chk("pred_target", bus.if_pred_target,         e_ptg);
            chk("mispredict",  {31'd0, bus.ex_mispredict}, {31'd0, e_mp});
            chk("redirect",    bus.ex_redirect_pc,         e_red);

            i   = idx_of(bus.ex_pc);
            hit = m_hit(bus.ex_pc);
            p_idx = i; p_valid = m_valid[i]; p_tag = m_tag[i];
            p_ctr = m_ctr[i]; p_tgt = m_tgt[i];
            if (bus.ex_valid) begin
                p_res = br || jal || jalr;
                p_mis = e_mp;
                if (jal) begin
                    p_en = 1; p_valid = 1; p_tag = tag_of(bus.ex_pc);
                    p_ctr = 3; p_tgt = bus.ex_target;
                end else if (jalr) begin
                    p_en = 1; p_valid = 0;
                end else if (br && hit) begin
                    p_en = 1;
                    if (bus.ex_taken) begin
                        p_ctr = (p_ctr == 3) ? 3 : p_ctr + 1;
                        p_tgt = bus.ex_target;
                    end else begin
                        p_ctr = (p_ctr == 0) ? 0 : p_ctr - 1;
                    end
                end else if (br && bus.ex_taken) begin
                    p_en = 1; p_valid = 1; p_tag = tag_of(bus.ex_pc);
                    p_ctr = 2; p_tgt = bus.ex_target;
                end else if (!br && hit) begin
                    p_en = 1; p_valid = 0;
                end
            end
        end
`ifdef BP_STATS_EN
        chk("stat_resolved",    stat_resolved,    m_res);
        chk("stat_mispredicts", stat_mispredicts, m_mis);
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input bit v, input logic [31:0] pc, input int kind, input bit tk,
                          input logic [31:0] tgt, input bit pt, input logic [31:0] ptg);
        bus.ex_valid       = v;
        bus.ex_pc          = pc;
        bus.ex_is_branch   = (kind == K_BR);
        bus.ex_is_jal      = (kind == K_JAL);
        bus.ex_is_jalr     = (kind == K_JALR);
        bus.ex_taken       = tk;
        bus.ex_target      = tgt;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptg;
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] pc;
        pc = ($urandom_range(0, 3) << (IDX + 2)) | ($urandom_range(0, 7) << 2);
        if ($urandom_range(0, 3) == 0) pc = pc | ($urandom() << (IDX + TAG_BITS + 2));
        if ($urandom_range(0, 49) == 0) pc = 32'hFFFF_FFFC;
        return pc;
    endfunction

    function automatic logic [31:0] rnd_tgt();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0: t = 32'h40;
            1: t = 32'h80;
            2: t = 32'hC0;
            default: t = $urandom();
        endcase
        return t;
    endfunction

    initial begin
        logic [31:0] tgt;
        bit          pt;
        bus.if_pc = 32'h100;
        ex_set(1, 32'h100, K_BR, 1, 32'h80, 0, 32'h0);
        #2;
        chk("lit_rst_pred", {31'd0, bus.if_pred_taken}, 32'd0);
        chk("lit_rst_mp",   {31'd0, bus.ex_mispredict}, 32'd0);
        chk("lit_rst_red",  bus.ex_redirect_pc,         32'd0);
        repeat (2) cyc();
        rst = 1'b0;
`ifdef BP_STATS_EN
        #1;
        chk("lit_stat_rst", stat_resolved | stat_mispredicts, 32'd0);
`endif
        // Allocate 0x100 -> 0x80; same-cycle lookup still sees the empty entry.
        #1;
        chk("lit_first_pred", {31'd0, bus.if_pred_taken}, 32'd0);
        chk("lit_first_tgt",  bus.if_pred_target,         32'd0);
        chk("lit_first_mp",   {31'd0, bus.ex_mispredict}, 32'd1);
        chk("lit_first_red",  bus.ex_redirect_pc,         32'h80);

        cyc(); ex_set(1, 32'h100, K_BR, 0, 32'h80, 1, 32'h80); #1;
        chk("lit_wt_pred", {31'd0, bus.if_pred_taken}, 32'd1);
        chk("lit_wt_tgt",  bus.if_pred_target,         32'h80);
        chk("lit_nt_mp",   {31'd0, bus.ex_mispredict}, 32'd1);
        chk("lit_nt_red",  bus.ex_redirect_pc,         32'h104);

        cyc(); ex_set(1, 32'h100, K_BR, 0, 32'h80, 0, 32'h0); #1;
        chk("lit_wnt_pred", {31'd0, bus.if_pred_taken}, 32'd0);
        chk("lit_nt2_mp",   {31'd0, bus.ex_mispredict}, 32'd0);
        chk("lit_nt2_red",  bus.ex_redirect_pc,         32'h104);

        // From SNT a single taken only reaches WNT, so still predicts not taken.
        cyc(); ex_set(1, 32'h100, K_BR, 1, 32'h80, 0, 32'h0); #1;
        chk("lit_snt_pred", {31'd0, bus.if_pred_taken}, 32'd0);
        cyc(); ex_set(0, 32'h0, K_NONE, 0, 32'h0, 0, 32'h0); #1;
        chk("lit_wnt2_pred", {31'd0, bus.if_pred_taken}, 32'd0);

        cyc(); bus.if_pc = 32'h200; ex_set(1, 32'h200, K_JAL, 0, 32'h40, 0, 32'h0); #1;
        chk("lit_jal_miss", {31'd0, bus.if_pred_taken}, 32'd0);
        chk("lit_jal_red",  bus.ex_redirect_pc,         32'h40);
        cyc(); ex_set(1, 32'h200, K_JALR, 0, 32'h60, 1, 32'h40); #1;
        chk("lit_jal_pred", {31'd0, bus.if_pred_taken}, 32'd1);
        chk("lit_jal_tgt",  bus.if_pred_target,         32'h40);
        chk("lit_jalr_mp",  {31'd0, bus.ex_mispredict}, 32'd1);
        chk("lit_jalr_red", bus.ex_redirect_pc,         32'h60);
        cyc(); ex_set(1, 32'h100, K_BR, 1, 32'h80, 0, 32'h0); #1;
        chk("lit_jalr_inv", {31'd0, bus.if_pred_taken}, 32'd0);

        // 0x100 and 0x200 share index 0 with different tags.
        cyc(); bus.if_pc = 32'h100; ex_set(1, 32'h200, K_BR, 1, 32'h300, 0, 32'h0); #1;
        chk("lit_alloc_pred", {31'd0, bus.if_pred_taken}, 32'd1);
        chk("lit_alloc_tgt",  bus.if_pred_target,         32'h80);
        cyc(); ex_set(0, 32'h300, K_BR, 1, 32'h500, 0, 32'h0); #1;
        chk("lit_alias_miss", {31'd0, bus.if_pred_taken}, 32'd0);
        chk("lit_bub_mp",     {31'd0, bus.ex_mispredict}, 32'd0);
        chk("lit_bub_red",    bus.ex_redirect_pc,         32'd0);
        cyc(); bus.if_pc = 32'h200; #1;
        chk("lit_alias_hit", bus.if_pred_target, 32'h300);
        cyc(); bus.if_pc = 32'h300; ex_set(1, 32'h400, K_BR, 1, 32'h500, 0, 32'h0); #1;
        chk("lit_bub_noalloc", {31'd0, bus.if_pred_taken}, 32'd0);
        rst = 1'b1; #1;
        chk("lit_midrst_mp",  {31'd0, bus.ex_mispredict}, 32'd0);
        chk("lit_midrst_red", bus.ex_redirect_pc,         32'd0);
        cyc(); rst = 1'b0; bus.if_pc = 32'h200; ex_set(0, 32'h0, K_NONE, 0, 32'h0, 0, 32'h0); #1;
        chk("lit_midrst_clr", {31'd0, bus.if_pred_taken}, 32'd0);
        cyc(); bus.if_pc = 32'h400; #1;
        chk("lit_midrst_disc", {31'd0, bus.if_pred_taken}, 32'd0);

        for (int n = 0; n < 4000; n++) begin
            cyc();
            if (rst) rst = 1'b0;
            bus.if_pc = ($urandom_range(0, 3) == 0) ? bus.ex_pc : rnd_pc();
            tgt = rnd_tgt();
            pt  = $urandom_range(0, 1);
            ex_set($urandom_range(0, 5) != 0, rnd_pc(), $urandom_range(0, 4) % 4,
                   $urandom_range(0, 1), tgt, pt,
                   ($urandom_range(0, 1) == 0) ? tgt : rnd_tgt());
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
            end
        end
        cyc();
        rst = 1'b0;
        ex_set(0, 32'h0, K_NONE, 0, 32'h0, 0, 32'h0);
        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
